// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the scoreboarded register file
//
// Purpose: FSM state type and default parameter values used by regfile_sb and rf_scoreboard.
// Ports:   none (package).
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-bit scoreboard with set/clear/flush priority
//
// Purpose: one pending bit per register; issue sets, writeback clears, flush clears all.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   en                1 while the register file is in RUN; all updates gated by it
//   issue_valid/rd    set request for issue_rd (index 0 ignored)
//   wb_valid/addr     clear request for wb_addr
//   flush             clear every bit (a same-cycle issue still sets its bit)
//   pending           current pending vector, bit 0 always 0
import regfile_pkg::*;

module rf_scoreboard #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Order of the assignments encodes priority: flush, then clear, then set.
  // The set is applied last so a newer producer issuing to the register
  // being written back (or issuing across a flush) stays pending.
  always_comb begin
    pend_d = pend_q;
    if (en) begin
      if (flush) begin
        pend_d = '0;
      end
      if (wb_valid) begin
        pend_d[wb_addr] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
        pend_d[issue_rd] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with write-through bypass and scoreboard
//
// Purpose: NUM_RD combinational read ports, one write port, pending tracking, SP init cycle.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   stackptr          value loaded into reg[SP_INDEX] during the INIT cycle
//   rd_addr/rd_data   packed read indices / bypassed read data, port p at [p*W +: W]
//   rd_ready          per-port operand valid
//   issue_valid/rd    marks issue_rd pending
//   wb_valid/addr/data writeback port
//   flush             clears the scoreboard
//   write_complete    one-cycle pulse after an accepted writeback
//   init_done         high once the INIT cycle has completed
//   pending           scoreboard bits
import regfile_pkg::*;

module regfile_sb #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int SP_INDEX   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        stackptr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  input  logic                         wb_valid,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         flush,
  output logic                         write_complete,
  output logic                         init_done,
  output logic [2**ADDR_WIDTH-1:0]     pending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  rf_state_e             state_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wc_q;
  logic                  init_done_q;
  logic                  run;

  assign run = (state_q == RF_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RF_INIT;
      wc_q        <= 1'b0;
      init_done_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        RF_INIT: begin
          regs_q[SP_INDEX] <= stackptr;
          init_done_q      <= 1'b1;
          wc_q             <= 1'b0;
          state_q          <= RF_RUN;
        end
        default: begin
          // Writes to index 0 are acknowledged but never stored.
          if (wb_valid && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
          end
          wc_q <= wb_valid;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .en          (run),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .pending     (pending)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    // Same-cycle writeback forwards to the reader and satisfies its hazard.
    assign hit  = run && wb_valid && (wb_addr == addr) && (wb_addr != '0);

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
        hit ? wb_data : ((addr == '0) ? '0 : regs_q[addr]);
    assign rd_ready[p] = run && ((addr == '0) || !pending[addr] || hit);
  end

  assign write_complete = wc_q;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  stackptr;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_ready;
  logic           issue_valid;
  logic [AW-1:0]  issue_rd;
  logic           wb_valid;
  logic [AW-1:0]  wb_addr;
  logic [DW-1:0]  wb_data;
  logic           flush;
  logic           write_complete;
  logic           init_done;
  logic [31:0]    pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .SP_INDEX   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stackptr       (stackptr),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .flush          (flush),
    .write_complete (write_complete),
    .init_done      (init_done),
    .pending        (pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdp(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    flush       = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    stackptr = 64'h8000;
    idle();
    set_rd(0, 0, 0, 0);
    #12;
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_wc", {63'd0, write_complete}, 64'd0);
    chk("rst_pending", {32'd0, pending}, 64'd0);
    chk("rst_ready", {60'd0, rd_ready}, 64'd0);

    // release reset: one INIT cycle, strobes must be ignored
    tick();
    reset = 1'b1;
    set_rd(5, 2, 3, 0);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h55;
    issue_valid = 1'b1; issue_rd = 5'd4;
    #1;
    chk("init_done_low", {63'd0, init_done}, 64'd0);
    chk("init_ready", {60'd0, rd_ready}, 64'd0);
    chk("init_no_bypass", rdp(2), 64'd0);
    chk("init_sp_not_yet", rdp(1), 64'd0);
    tick();
    idle();
    #1;
    chk("run_init_done", {63'd0, init_done}, 64'd1);
    chk("run_sp", rdp(1), 64'h8000);
    chk("init_wb_ignored", rdp(2), 64'd0);
    chk("init_wc_none", {63'd0, write_complete}, 64'd0);
    chk("init_issue_ignored", {32'd0, pending}, 64'd0);
    chk("run_ready_all", {60'd0, rd_ready}, 64'hF);

    // bypass on write
    set_rd(5, 0, 0, 0);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD;
    #1;
    chk("bypass_data", rdp(0), 64'hDEAD);
    chk("wc_not_yet", {63'd0, write_complete}, 64'd0);
    tick();
    idle();
    #1;
    chk("wc_pulse", {63'd0, write_complete}, 64'd1);
    chk("reg5_stored", rdp(0), 64'hDEAD);
    tick();
    chk("wc_drop", {63'd0, write_complete}, 64'd0);

    // write to index 0 is discarded but acknowledged
    set_rd(0, 0, 0, 0);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF;
    #1;
    chk("r0_no_bypass", rdp(0), 64'd0);
    tick();
    idle();
    #1;
    chk("r0_wc_pulse", {63'd0, write_complete}, 64'd1);
    chk("r0_reads_zero", rdp(0), 64'd0);

    // issue 7, then writeback 7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    set_rd(7, 7, 0, 5);
    #1;
    chk("pend7_set", {32'd0, pending}, 64'h80);
    chk("pend7_ready", {60'd0, rd_ready}, 64'hC);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 64'h77;
    #1;
    chk("pend7_bypass_ready", {60'd0, rd_ready}, 64'hF);
    chk("pend7_bypass_data", rdp(1), 64'h77);
    tick();
    idle();
    #1;
    chk("pend7_cleared", {32'd0, pending}, 64'd0);
    chk("reg7_stored", rdp(0), 64'h77);

    // issue and writeback same index: set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h99;
    tick();
    idle();
    set_rd(9, 9, 9, 9);
    #1;
    chk("pend9_set_wins", {32'd0, pending}, 64'h200);
    chk("pend9_not_ready", {60'd0, rd_ready}, 64'h0);
    chk("reg9_stored", rdp(0), 64'h99);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h999;
    tick();
    idle();
    #1;
    chk("pend9_cleared", {32'd0, pending}, 64'd0);

    // flush with concurrent issue and writeback
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    idle();
    #1;
    chk("pend_3_4", {32'd0, pending}, 64'h18);
    flush = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd6;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 64'hAA;
    tick();
    idle();
    set_rd(6, 6, 6, 6);
    #1;
    chk("flush_keeps_issue", {32'd0, pending}, 64'h40);
    chk("flush_ready6", {60'd0, rd_ready}, 64'h0);
    set_rd(10, 6, 6, 6);
    #1;
    chk("flush_wb_written", rdp(0), 64'hAA);

    // reset mid-run
    set_rd(5, 2, 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_pending", {32'd0, pending}, 64'd0);
    chk("mid_rst_init_done", {63'd0, init_done}, 64'd0);
    chk("mid_rst_reg5", rdp(0), 64'd0);
    chk("mid_rst_reg2", rdp(1), 64'd0);
    stackptr = 64'h4000;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_init_done_low", {63'd0, init_done}, 64'd0);
    chk("mid_init_ready", {60'd0, rd_ready}, 64'd0);
    tick();
    #1;
    chk("mid_init_done_high", {63'd0, init_done}, 64'd1);
    chk("mid_sp", rdp(1), 64'h4000);
    chk("mid_reg5_zero", rdp(0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
